// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one UART byte transmitter between NUM_REQ sources.
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      tx_valid_o,
   output logic [DATA_W-1:0]         tx_data_o,
   input  logic                      tx_ready_i,
   output logic [ID_W-1:0]           grant_id_o,
   output logic                      busy_o,
   output logic                      timeout_err_o
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W-1:0] req_data_arr [NUM_REQ];
   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   next_ptr;
   logic              handshake;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid_i[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] stall_q, stall_d;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      tx_valid_o  = 1'b0;
      tx_data_o   = req_data_arr[grant_q];
      req_ready_o = '0;
      handshake   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_d     = stall_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               busy_d  = 1'b1;
               state_d = XFER;
`ifdef UART_ARB_TIMEOUT_EN
               stall_d = '0;
`endif
            end
         end
         XFER: begin
            tx_valid_o           = req_valid_i[grant_q];
            req_ready_o[grant_q] = tx_ready_i;
            handshake            = req_valid_i[grant_q] & tx_ready_i;
            if (handshake && req_last_i[grant_q]) begin
               busy_d   = 1'b0;
               rr_ptr_d = next_ptr;
               state_d  = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (handshake) begin
               stall_d = '0;
            end else if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               rr_ptr_d  = next_ptr;
               state_d   = IDLE;
            end else begin
               stall_d = stall_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_q <= '0;
      else         stall_q <= stall_d;
   end
`endif

   assign grant_id_o    = grant_q;
   assign busy_o        = busy_q;
   assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, round-robin order, grant hold,
// backpressure, async reset and (with UART_ARB_TIMEOUT_EN) the stall watchdog.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [1:0]  grant_id;
   logic        busy;
   logic        timeout_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_last_i   (req_last),
      .req_ready_o  (req_ready),
      .tx_valid_o   (tx_valid),
      .tx_data_o    (tx_data),
      .tx_ready_i   (tx_ready),
      .grant_id_o   (grant_id),
      .busy_o       (busy),
      .timeout_err_o(timeout_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic tr);
      req_valid = v;
      req_data  = d;
      req_last  = l;
      tx_ready  = tr;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_g [5];
      int exp_d [5];
      exp_g = '{0, 1, 2, 3, 0};
      exp_d = '{'h10, 'h11, 'h12, 'h13, 'h10};
      rst_n = 1'b0;
      set(4'b0000, 32'h0, 4'b0000, 1'b0);
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_timeout", timeout_err, 0);
      rst_n = 1'b1;

      // 1: three-byte packet from requester 0
      set(4'b0001, 32'h000000A1, 4'b0000, 1'b1);
      #1;
      chk("t1_idle_tx_valid", tx_valid, 0);
      chk("t1_idle_ready", req_ready, 0);
      step();
      chk("t1_busy", busy, 1);
      chk("t1_grant", grant_id, 0);
      chk("t1_tx_valid", tx_valid, 1);
      chk("t1_a1", tx_data, 'hA1);
      chk("t1_ready", req_ready, 4'b0001);
      step();
      set(4'b0001, 32'h000000A2, 4'b0000, 1'b1);
      #1;
      chk("t1_a2", tx_data, 'hA2);
      step();
      set(4'b0001, 32'h000000A3, 4'b0001, 1'b1);
      #1;
      chk("t1_a3", tx_data, 'hA3);
      step();
      set(4'b0000, 32'h0, 4'b0000, 1'b1);
      #1;
      chk("t1_done_busy", busy, 0);
      chk("t1_done_tx_valid", tx_valid, 0);

      // 2: round-robin order from a fresh rr_ptr
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      set(4'b1111, 32'h13121110, 4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_gap_tx_valid", tx_valid, 0);
         step();
         chk("t2_grant", grant_id, exp_g[i]);
         chk("t2_data", tx_data, exp_d[i]);
         step();
      end
      set(4'b0000, 32'h0, 4'b0000, 1'b1);

      // 3: requester 1 waits while requester 2 holds the grant
      set(4'b0100, 32'h00312100, 4'b0000, 1'b1);
      step();
      chk("t3_grant2", grant_id, 2);
      chk("t3_b1", tx_data, 'h31);
      set(4'b0110, 32'h00312100, 4'b0000, 1'b1);
      #1;
      chk("t3_hold_ready", req_ready, 4'b0100);
      step();
      set(4'b0110, 32'h00322100, 4'b0110, 1'b1);
      #1;
      chk("t3_b2", tx_data, 'h32);
      chk("t3_last_ready", req_ready, 4'b0100);
      step();
      set(4'b0010, 32'h00002100, 4'b0010, 1'b1);
      #1;
      chk("t3_idle_busy", busy, 0);
      chk("t3_idle_tx_valid", tx_valid, 0);
      step();
      chk("t3_grant1", grant_id, 1);
      chk("t3_r1_data", tx_data, 'h21);
      chk("t3_r1_ready", req_ready, 4'b0010);
      step();
      set(4'b0000, 32'h0, 4'b0000, 1'b1);
      #1;
      chk("t3_done_busy", busy, 0);

      // 4: backpressure and tx_ready without tx_valid
      set(4'b0001, 32'h00000041, 4'b0000, 1'b1);
      step();
      chk("t4_grant", grant_id, 0);
      chk("t4_b1", tx_data, 'h41);
      chk("t4_b1_ready", req_ready, 4'b0001);
      step();
      set(4'b0001, 32'h00000042, 4'b0001, 1'b0);
      #1;
      chk("t4_stall_valid", tx_valid, 1);
      chk("t4_stall_data", tx_data, 'h42);
      chk("t4_stall_ready", req_ready, 4'b0000);
      step();
      set(4'b0000, 32'h00000042, 4'b0001, 1'b1);
      #1;
      chk("t4_novalid_tx_valid", tx_valid, 0);
      step();
      chk("t4_still_busy", busy, 1);
      set(4'b0001, 32'h00000042, 4'b0001, 1'b1);
      #1;
      chk("t4_b2_data", tx_data, 'h42);
      chk("t4_b2_valid", tx_valid, 1);
      step();
      set(4'b0000, 32'h0, 4'b0000, 1'b1);
      #1;
      chk("t4_done_busy", busy, 0);

      // 5: asynchronous reset mid-packet; next grant scans from requester 0
      set(4'b0010, 32'h00005100, 4'b0000, 1'b1);
      step();
      chk("t5_grant1", grant_id, 1);
      chk("t5_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_tx_valid", tx_valid, 0);
      chk("t5_rst_ready", req_ready, 0);
      step();
      rst_n = 1'b1;
      set(4'b1001, 32'h61000060, 4'b0000, 1'b1);
      step();
      chk("t5_regrant", grant_id, 0);
      chk("t5_data", tx_data, 'h60);

`ifdef UART_ARB_TIMEOUT_EN
      // 6: granted requester 0 stalls; watchdog releases to requester 1
      set(4'b0010, 32'h00007100, 4'b0010, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("t6_stall_busy", busy, 1);
         chk("t6_stall_timeout", timeout_err, 0);
      end
      step();
      chk("t6_timeout", timeout_err, 1);
      chk("t6_released", busy, 0);
      step();
      chk("t6_pulse_end", timeout_err, 0);
      chk("t6_grant1", grant_id, 1);
      chk("t6_data", tx_data, 'h71);
      step();
`else
      set(4'b0001, 32'h00000062, 4'b0001, 1'b1);
      #1;
      chk("t6_last_ready", req_ready, 4'b0001);
      chk("t6_last_data", tx_data, 'h62);
      step();
      chk("t6_done_busy", busy, 0);
      chk("t6_no_timeout", timeout_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
